// File: rtl/meter_time_accum.sv
// Parking/traffic meter time accumulator: coin credit, 1 Hz countdown, saturation and held presets.
// Optional build macro METER_AUDIT_EN adds a 32-bit wrapping audit_total of nominal credited coin values.
module meter_time_accum #(
  parameter int WIDTH        = 14,
  parameter int MAX_TIME     = 9999,
  parameter int COIN0_VAL    = 10,
  parameter int COIN1_VAL    = 180,
  parameter int COIN2_VAL    = 200,
  parameter int COIN3_VAL    = 550,
  parameter int PRESET_A_VAL = 10,
  parameter int PRESET_B_VAL = 205
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             tick_1hz,
  input  logic [3:0]       coin,
  input  logic             preset_a,
  input  logic             preset_b,
  output logic [WIDTH-1:0] time_remain,
  output logic             expired,
  output logic             coin_accepted,
  output logic [1:0]       state
`ifdef METER_AUDIT_EN
  ,
  output logic [31:0]      audit_total
`endif
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PA   = 2'b10;
  localparam logic [1:0] ST_PB   = 2'b11;

  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_TIME);
  localparam logic [WIDTH:0]   C0_W  = (WIDTH+1)'(COIN0_VAL);
  localparam logic [WIDTH:0]   C1_W  = (WIDTH+1)'(COIN1_VAL);
  localparam logic [WIDTH:0]   C2_W  = (WIDTH+1)'(COIN2_VAL);
  localparam logic [WIDTH:0]   C3_W  = (WIDTH+1)'(COIN3_VAL);
  localparam logic [WIDTH-1:0] PA_W  = WIDTH'(PRESET_A_VAL);
  localparam logic [WIDTH-1:0] PB_W  = WIDTH'(PRESET_B_VAL);

  function automatic logic [WIDTH-1:0] sat_max(input logic [WIDTH:0] s);
    if (s > MAX_W) sat_max = MAX_W[WIDTH-1:0];
    else           sat_max = s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] time_q, time_d;
  logic [1:0]       state_q, state_d;
  logic             expired_q, expired_d;
  logic             acc_q, acc_d;
  logic [3:0]       coin_prev_q, coin_prev_d;
  logic [3:0]       ev;
  logic [1:0]       sel;
  logic             hit;
  logic [WIDTH:0]   add, dec, sum;

  always_comb begin
    ev          = coin & ~coin_prev_q;
    coin_prev_d = sample_en ? coin : coin_prev_q;
    hit         = sample_en && (ev != 4'b0000);
    // Lowest-numbered new edge wins; other simultaneous edges are swallowed by coin_prev.
    if (ev[0])      sel = 2'd0;
    else if (ev[1]) sel = 2'd1;
    else if (ev[2]) sel = 2'd2;
    else            sel = 2'd3;
    case (sel)
      2'd0:    add = C0_W;
      2'd1:    add = C1_W;
      2'd2:    add = C2_W;
      default: add = C3_W;
    endcase
    if (!hit) add = '0;
    dec = (tick_1hz && time_q != '0) ? (WIDTH+1)'(1) : '0;
    sum = {1'b0, time_q} - dec + add;

    state_d = state_q;
    time_d  = time_q;
    acc_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (sample_en && preset_a)      state_d = ST_PA;
        else if (sample_en && preset_b) state_d = ST_PB;
        else begin
          acc_d  = hit;
          time_d = sat_max(sum);
          if (hit)                                           state_d = ST_RUN;
          else if (state_q == ST_RUN && dec != '0 && sum == '0) state_d = ST_IDLE;
        end
      end
      default: begin
        // Release edge keeps the held preset value and always resumes in RUN.
        time_d = (state_q == ST_PA) ? PA_W : PB_W;
        if (sample_en) begin
          if (preset_a)      state_d = ST_PA;
          else if (preset_b) state_d = ST_PB;
          else               state_d = ST_RUN;
        end
      end
    endcase
    if (state_d == ST_PA) time_d = PA_W;
    if (state_d == ST_PB) time_d = PB_W;

    if (state_d == ST_PA || state_d == ST_PB) expired_d = 1'b0;
    else if (state_d == ST_IDLE)              expired_d = 1'b1;
    else                                      expired_d = (time_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q      <= '0;
      state_q     <= ST_IDLE;
      expired_q   <= 1'b1;
      acc_q       <= 1'b0;
      coin_prev_q <= 4'b0000;
    end else begin
      time_q      <= time_d;
      state_q     <= state_d;
      expired_q   <= expired_d;
      acc_q       <= acc_d;
      coin_prev_q <= coin_prev_d;
    end
  end

`ifdef METER_AUDIT_EN
  logic [31:0] audit_q, nom;
  always_comb begin
    case (sel)
      2'd0:    nom = 32'(COIN0_VAL);
      2'd1:    nom = 32'(COIN1_VAL);
      2'd2:    nom = 32'(COIN2_VAL);
      default: nom = 32'(COIN3_VAL);
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset)      audit_q <= '0;
    else if (acc_d) audit_q <= audit_q + nom;
  end
  assign audit_total = audit_q;
`endif

  assign time_remain   = time_q;
  assign state         = state_q;
  assign expired       = expired_q;
  assign coin_accepted = acc_q;

endmodule

// File: tb/tb_meter_time_accum.sv
// Directed self-checking bench for meter_time_accum with hand-computed expectations.
module tb_meter_time_accum;

  logic        clk = 1'b0;
  logic        reset, sample_en, tick_1hz, preset_a, preset_b;
  logic [3:0]  coin;
  logic [13:0] time_remain;
  logic        expired, coin_accepted;
  logic [1:0]  state;
`ifdef METER_AUDIT_EN
  logic [31:0] audit_total;
`endif

  int checks = 0;
  int errors = 0;
  int pulses;

  meter_time_accum dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .tick_1hz(tick_1hz),
    .coin(coin), .preset_a(preset_a), .preset_b(preset_b),
    .time_remain(time_remain), .expired(expired), .coin_accepted(coin_accepted),
    .state(state)
`ifdef METER_AUDIT_EN
    , .audit_total(audit_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are read 1 ns after the edge.
  task automatic cyc(input logic s, input logic t);
    sample_en = s;
    tick_1hz  = t;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    tick_1hz  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic coin_pulse(input logic [3:0] c);
    coin = c;
    cyc(1'b1, 1'b0);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; tick_1hz = 1'b0;
    coin = 4'b0000; preset_a = 1'b0; preset_b = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset = 1'b0;
    check("rst_time", time_remain, 0);
    check("rst_expired", expired, 1);
    check("rst_state", state, 0);
    check("rst_acc", coin_accepted, 0);

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    check("idle_tick_time", time_remain, 0);
    check("idle_tick_expired", expired, 1);
    check("idle_tick_state", state, 0);

    // Coin edge without sample_en is not seen.
    coin = 4'b0010;
    cyc(1'b0, 1'b0);
    check("nosample_acc", coin_accepted, 0);
    check("nosample_time", time_remain, 0);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      if (i == 0) begin
        check("coin1_time", time_remain, 180);
        check("coin1_state", state, 1);
        check("coin1_expired", expired, 0);
      end
      pulses += coin_accepted;
    end
    check("coin1_pulses", pulses, 1);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    check("coin1_ticks", time_remain, 177);

    // Saturation.
    do_reset();
    for (int i = 0; i < 18; i++) coin_pulse(4'b1000);
    check("preload_9900", time_remain, 9900);
    coin = 4'b0100;
    cyc(1'b1, 1'b0);
    check("sat_time", time_remain, 9999);
    check("sat_acc", coin_accepted, 1);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("sat_tick", time_remain, 9998);

    // Tick and coin together at 1, then expiry.
    do_reset();
    coin_pulse(4'b0001);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
    check("at_one", time_remain, 1);
    coin = 4'b0001;
    cyc(1'b1, 1'b1);
    check("tick_coin_time", time_remain, 10);
    check("tick_coin_state", state, 1);
    check("tick_coin_acc", coin_accepted, 1);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("expire_time", time_remain, 0);
    check("expire_expired", expired, 1);
    check("expire_state", state, 0);
    cyc(1'b0, 1'b1);
    check("no_underflow", time_remain, 0);

    // Simultaneous edges: coin1 outranks coin2.
    coin = 4'b0110;
    cyc(1'b1, 1'b0);
    check("prio_time", time_remain, 180);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);

    // Presets.
    preset_a = 1'b1; preset_b = 1'b1;
    cyc(1'b1, 1'b0);
    check("pa_state", state, 2);
    check("pa_time", time_remain, 10);
    check("pa_expired", expired, 0);
    coin = 4'b1000;
    cyc(1'b1, 1'b1);
    check("pa_ignore_time", time_remain, 10);
    check("pa_ignore_acc", coin_accepted, 0);
    preset_a = 1'b0;
    cyc(1'b1, 1'b0);
    check("pb_state", state, 3);
    check("pb_time", time_remain, 205);
    preset_b = 1'b0;
    cyc(1'b1, 1'b0);
    check("rel_state", state, 1);
    check("rel_time", time_remain, 205);
    coin = 4'b0000;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    check("rel_ticks", time_remain, 203);

    // Reset during PRESET_B with a coin held high.
    preset_b = 1'b1;
    coin = 4'b0001;
    cyc(1'b1, 1'b0);
    check("pb2_state", state, 3);
    reset = 1'b1;
    cyc(1'b1, 1'b1);
    check("midrst_time", time_remain, 0);
    check("midrst_state", state, 0);
    check("midrst_expired", expired, 1);
    check("midrst_acc", coin_accepted, 0);
    reset = 1'b0;
    preset_b = 1'b0;
    cyc(1'b1, 1'b0);
    check("held_coin_time", time_remain, 10);
    check("held_coin_acc", coin_accepted, 1);
    cyc(1'b1, 1'b0);
    check("held_coin_once", coin_accepted, 0);
    coin = 4'b0000;

    do_reset();
`ifdef METER_AUDIT_EN
    check("audit_rst", audit_total, 0);
`endif
    coin_pulse(4'b1000);
    coin_pulse(4'b0001);
    check("c3c0_time", time_remain, 560);
`ifdef METER_AUDIT_EN
    check("audit_total", audit_total, 560);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
